// File: rtl/multiply_serial.sv
// ---------------------------------------------------------------------------
// multiply_serial
//   Rebuilds the dividend a = c * b from an unsigned I8F8 quotient c and an
//   unsigned I8F0 divisor b, rounded (half up) and saturated to I8F0.
//   Serial shift-add core: one divisor bit is consumed per cycle, so one
//   operation takes DATA_WD busy cycles plus one DONE cycle.
//
// Ports
//   clk      in   1                 clock, all logic on posedge
//   rstn     in   1                 synchronous reset, active-low
//   val_i    in   1                 operand valid, accepted when val_i & rdy_o
//   dat_c_i  in   DATA_WD+FRAC_WD   quotient c, unsigned I8F8
//   dat_b_i  in   DATA_WD           divisor b, unsigned I8F0
//   rdy_o    out  1                 ready for a new operand pair
//   val_o    out  1                 one-cycle pulse, result valid
//   dat_a_o  out  DATA_WD           rounded, saturated product, I8F0
//   sat_o    out  1                 product saturated (qualified by val_o)
// ---------------------------------------------------------------------------
module multiply_serial #(
  parameter int DATA_WD = 8,
  parameter int FRAC_WD = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       val_i,
  input  logic [DATA_WD+FRAC_WD-1:0] dat_c_i,
  input  logic [DATA_WD-1:0]         dat_b_i,
  output logic                       rdy_o,
  output logic                       val_o,
  output logic [DATA_WD-1:0]         dat_a_o,
  output logic                       sat_o
);

  // Full exact product c*b: I16F8 for the default widths.
  localparam int ACC_WD = 2*DATA_WD + FRAC_WD;
  localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);
  // Half of one output LSB, added before truncating the fraction.
  localparam logic [ACC_WD:0]   HALF_LSB = {{ACC_WD{1'b0}}, 1'b1} << (FRAC_WD - 1);
  localparam logic [ACC_WD:0]   OUT_MAX  = {{(ACC_WD+1-DATA_WD){1'b0}}, {DATA_WD{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [ACC_WD-1:0]     acc_r;
  logic [ACC_WD-1:0]     c_sh_r;
  logic [DATA_WD-1:0]    b_sh_r;
  logic [CNT_WD-1:0]     cnt_r;
  logic [ACC_WD-1:0]     acc_next_s;

  // Round half up and saturate the exact product; returns {sat, data}.
  // The rounded value is compared at full width so any carry past the
  // output range is seen as saturation.
  function automatic logic [DATA_WD:0] round_sat(input logic [ACC_WD-1:0] prod);
    logic [ACC_WD:0] rnd;
    logic [DATA_WD:0] res;
    rnd = ({1'b0, prod} + HALF_LSB) >> FRAC_WD;
    if (rnd > OUT_MAX) begin
      res = {1'b1, {DATA_WD{1'b1}}};
    end else begin
      res = {1'b0, rnd[DATA_WD-1:0]};
    end
    return res;
  endfunction

  // Accumulator after the current iteration's conditional add.
  always_comb begin
    acc_next_s = acc_r;
    if (b_sh_r[0]) begin
      acc_next_s = acc_r + c_sh_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      acc_r   <= {ACC_WD{1'b0}};
      c_sh_r  <= {ACC_WD{1'b0}};
      b_sh_r  <= {DATA_WD{1'b0}};
      cnt_r   <= {CNT_WD{1'b0}};
      rdy_o   <= 1'b1;
      val_o   <= 1'b0;
      dat_a_o <= {DATA_WD{1'b0}};
      sat_o   <= 1'b0;
    end else begin
      case (state_r)
        // DONE accepts like IDLE so back-to-back operation loses no cycle.
        ST_IDLE, ST_DONE: begin
          val_o <= 1'b0;
          if (val_i) begin
            c_sh_r  <= {{DATA_WD{1'b0}}, dat_c_i};
            b_sh_r  <= dat_b_i;
            acc_r   <= {ACC_WD{1'b0}};
            cnt_r   <= {CNT_WD{1'b0}};
            state_r <= ST_BUSY;
            rdy_o   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            rdy_o   <= 1'b1;
          end
        end
        ST_BUSY: begin
          acc_r  <= acc_next_s;
          c_sh_r <= c_sh_r << 1;
          b_sh_r <= b_sh_r >> 1;
          cnt_r  <= cnt_r + CNT_WD'(1);
          if (cnt_r == CNT_LAST) begin
            // Last bit: the result uses the accumulator including this add.
            state_r            <= ST_DONE;
            rdy_o              <= 1'b1;
            val_o              <= 1'b1;
            {sat_o, dat_a_o}   <= round_sat(acc_next_s);
          end else begin
            state_r <= ST_BUSY;
            rdy_o   <= 1'b0;
            val_o   <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rdy_o   <= 1'b1;
          val_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_serial.sv
module tb_multiply_serial;

  logic        clk = 1'b0;
  logic        rstn;
  logic        val_i;
  logic [15:0] dat_c_i;
  logic [7:0]  dat_b_i;
  logic        rdy_o;
  logic        val_o;
  logic [7:0]  dat_a_o;
  logic        sat_o;

  int n_checks = 0;
  int n_fail   = 0;

  multiply_serial #(.DATA_WD(8), .FRAC_WD(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .val_i   (val_i),
    .dat_c_i (dat_c_i),
    .dat_b_i (dat_b_i),
    .rdy_o   (rdy_o),
    .val_o   (val_o),
    .dat_a_o (dat_a_o),
    .sat_o   (sat_o)
  );

  always #5 clk = ~clk;

  // Reference: round((c*b)/256) half up, saturated to 8 bits; returns {sat, a}.
  function automatic logic [8:0] ref_mul(input logic [15:0] c, input logic [7:0] b);
    int unsigned p;
    int unsigned r;
    p = 32'(c) * 32'(b);
    r = (p + 32'd128) / 32'd256;
    if (r > 32'd255) return {1'b1, 8'hFF};
    return {1'b0, r[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one operation in flight, result due 8 edges
  // after the accepting edge, next accept allowed 9 edges after it.
  int         edge_n   = 0;
  int         pend_due = -1;
  int         next_ok  = 0;
  logic [8:0] pend_res = 9'd0;
  logic [7:0] hold_dat = 8'd0;
  logic       hold_sat = 1'b0;
  logic       exp_val  = 1'b0;
  logic       exp_rdy  = 1'b1;
  logic       started  = 1'b0;

  always @(posedge clk) begin : model
    int e;
    e = edge_n + 1;
    edge_n <= e;
    if (!rstn) started <= 1'b1;
    if (!rstn) begin
      pend_due <= -1;
      next_ok  <= e + 1;
      hold_dat <= 8'd0;
      hold_sat <= 1'b0;
      exp_val  <= 1'b0;
      exp_rdy  <= 1'b1;
    end else begin
      exp_val <= (pend_due == e);
      if (pend_due == e) {hold_sat, hold_dat} <= pend_res;
      if (val_i && e >= next_ok) begin
        pend_res <= ref_mul(dat_c_i, dat_b_i);
        pend_due <= e + 8;
        next_ok  <= e + 9;
        exp_rdy  <= 1'b0;
      end else begin
        exp_rdy  <= (e + 1 >= next_ok);
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      check("cyc_rdy_o",   32'(rdy_o),   32'(exp_rdy));
      check("cyc_val_o",   32'(val_o),   32'(exp_val));
      check("cyc_dat_a_o", 32'(dat_a_o), 32'(hold_dat));
      check("cyc_sat_o",   32'(sat_o),   32'(hold_sat));
    end
  end

  // One operation from an idle DUT against hand-computed literals.
  task automatic run_op(input logic [15:0] c, input logic [7:0] b,
                        input logic [7:0] ea, input logic es);
    int k;
    k = 0;
    check("model_literal", 32'(ref_mul(c, b)), 32'({es, ea}));
    @(negedge clk);
    dat_c_i = c;
    dat_b_i = b;
    val_i   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) val_i = 1'b0;
      if (val_o) begin
        k = i;
        break;
      end
    end
    check("latency", 32'(k), 32'd9);
    if (k != 0) begin
      check("op_dat_a_o", 32'(dat_a_o), 32'(ea));
      check("op_sat_o",   32'(sat_o),   32'(es));
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rstn    = 1'b0;
    val_i   = 1'b0;
    dat_c_i = 16'h0000;
    dat_b_i = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rdy_o",   32'(rdy_o),   32'd1);
    check("rst_val_o",   32'(val_o),   32'd0);
    check("rst_dat_a_o", 32'(dat_a_o), 32'd0);
    check("rst_sat_o",   32'(sat_o),   32'd0);
    rstn = 1'b1;

    // Directed vectors with hand-computed results.
    run_op(16'h0280, 8'd4,   8'd10,  1'b0);
    run_op(16'h0155, 8'd3,   8'd4,   1'b0);
    run_op(16'h0080, 8'd1,   8'd1,   1'b0);
    run_op(16'hFFFF, 8'hFF,  8'hFF,  1'b1);
    run_op(16'h0000, 8'hFF,  8'd0,   1'b0);
    run_op(16'h1234, 8'h00,  8'd0,   1'b0);
    run_op(16'h0040, 8'd1,   8'd0,   1'b0);
    run_op(16'h00FF, 8'd1,   8'd1,   1'b0);
    run_op(16'hFF7F, 8'd1,   8'hFF,  1'b0);
    run_op(16'hFF80, 8'd1,   8'hFF,  1'b1);
    run_op(16'h0180, 8'hAB,  8'hFF,  1'b1);
    run_op(16'h0100, 8'd7,   8'd7,   1'b0);

    // val_i held high while operands change every cycle.
    @(negedge clk);
    val_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dat_c_i = 16'($urandom);
      dat_b_i = 8'($urandom);
      @(negedge clk);
    end
    val_i = 1'b0;
    repeat (12) @(negedge clk);

    // Reset on the 4th busy edge aborts the operation.
    dat_c_i = 16'h0280;
    dat_b_i = 8'd4;
    val_i   = 1'b1;
    @(negedge clk);
    val_i = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_rdy_o",   32'(rdy_o),   32'd1);
    check("abort_val_o",   32'(val_o),   32'd0);
    check("abort_dat_a_o", 32'(dat_a_o), 32'd0);
    check("abort_sat_o",   32'(sat_o),   32'd0);
    run_op(16'h0100, 8'd7, 8'd7, 1'b0);

    // Random back-to-back traffic with occasional corner operands.
    @(negedge clk);
    val_i = 1'b1;
    for (int i = 0; i < 18000; i++) begin
      case ($urandom_range(0, 7))
        0:       dat_c_i = 16'hFFFF;
        1:       dat_c_i = 16'h0000;
        default: dat_c_i = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       dat_b_i = 8'hFF;
        1:       dat_b_i = 8'h00;
        default: dat_b_i = 8'($urandom);
      endcase
      @(negedge clk);
    end
    val_i = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
